// File: rtl/frec_pkg.sv
// Shared clock-rate constants, standard divisors and one-shot FSM encoding
// for the frec tick generator.
package frec_pkg;

   localparam int CLK_HZ   = 100_000_000;
   localparam int DIV_1HZ  = CLK_HZ;
   localparam int DIV_10HZ = CLK_HZ / 10;
   localparam int DIV_1KHZ = CLK_HZ / 1000;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/frec_div_shadow.sv
// Divisor shadow register: accepts runtime divisor loads, rejects zero with a
// sticky error, and flags a pending update until the top level applies it.
module frec_div_shadow
   import frec_pkg::*;
#(
   parameter int               WIDTH       = 28,
   parameter logic [WIDTH-1:0] DIV_DEFAULT = WIDTH'(DIV_1HZ)
) (
   input  logic             CLK,
   input  logic             reset,
   input  logic             div_load,
   input  logic [WIDTH-1:0] div_val,
   input  logic             apply,
   output logic [WIDTH-1:0] shadow,
   output logic             pending,
   output logic             div_err
);

   logic load_ok;
   logic load_bad;

   assign load_ok  = div_load & (div_val != '0);
   assign load_bad = div_load & (div_val == '0);

   always_ff @(posedge CLK) begin
      if (reset) begin
         shadow  <= DIV_DEFAULT;
         pending <= 1'b0;
         div_err <= 1'b0;
      end else begin
         if (load_ok) begin
            shadow <= div_val;
         end
         // A load landing on the apply cycle stays pending for the next one.
         if (load_ok) begin
            pending <= 1'b1;
         end else if (apply) begin
            pending <= 1'b0;
         end
         if (load_bad) begin
            div_err <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/frec_tick_gen.sv
// Free-running period counter emitting a one-cycle tick every div_active cycles,
// continuous or one-shot. Optional square output under FREC_SQUARE_OUT_EN.
module frec_tick_gen
   import frec_pkg::*;
#(
   parameter int               WIDTH       = 28,
   parameter logic [WIDTH-1:0] DIV_DEFAULT = WIDTH'(DIV_1HZ)
) (
   input  logic             CLK,
   input  logic             reset,
   input  logic             en,
   input  logic             oneshot,
   input  logic             start,
   input  logic             div_load,
   input  logic [WIDTH-1:0] div_val,
   output logic             tick,
   output logic             busy,
   output logic             div_err,
   output logic [WIDTH-1:0] count,
   output logic [WIDTH-1:0] div_active
`ifdef FREC_SQUARE_OUT_EN
   ,
   output logic             sq_out
`endif
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   state_t           state;
   state_t           state_nxt;
   logic             running;
   logic             wrap;
   logic             start_shot;
   logic             apply;
   logic             pending;
   logic [WIDTH-1:0] shadow;

   frec_div_shadow #(
      .WIDTH       (WIDTH),
      .DIV_DEFAULT (DIV_DEFAULT)
   ) u_div_shadow (
      .CLK      (CLK),
      .reset    (reset),
      .div_load (div_load),
      .div_val  (div_val),
      .apply    (apply),
      .shadow   (shadow),
      .pending  (pending),
      .div_err  (div_err)
   );

   // A shot in flight finishes as one-shot even if oneshot drops mid-period.
   assign busy       = (state == RUN);
   assign running    = busy ? en : (en & ~oneshot);
   assign wrap       = running & (count == div_active - ONE);
   assign start_shot = (state == IDLE) & oneshot & start;
   assign apply      = pending & (wrap | ~running);

   always_ff @(posedge CLK) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      // NOTE: default assigned first so no path leaves state_nxt unassigned (no latch).
      state_nxt = state;
      case (state)
         IDLE:    if (start_shot) state_nxt = RUN;
         RUN:     if (wrap)       state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge CLK) begin
      if (reset) begin
         count      <= '0;
         tick       <= 1'b0;
         div_active <= DIV_DEFAULT;
      end else begin
         tick <= wrap;
         if (start_shot || wrap) begin
            count <= '0;
         end else if (running) begin
            count <= count + ONE;
         end else if (apply && (shadow != div_active)) begin
            count <= '0;
         end
         if (apply) begin
            div_active <= shadow;
         end
      end
   end

`ifdef FREC_SQUARE_OUT_EN
   always_ff @(posedge CLK) begin
      if (reset) begin
         sq_out <= 1'b0;
      end else if (wrap) begin
         sq_out <= ~sq_out;
      end
   end
`endif

endmodule

// File: tb/tb_frec_tick_gen.sv
// Directed bench for frec_tick_gen with DIV_DEFAULT = 5; square-output checks
// are compiled in when FREC_SQUARE_OUT_EN is defined.
module tb_frec_tick_gen;

   localparam int W = 28;

   logic         CLK;
   logic         reset;
   logic         en;
   logic         oneshot;
   logic         start;
   logic         div_load;
   logic [W-1:0] div_val;
   logic         tick;
   logic         busy;
   logic         div_err;
   logic [W-1:0] count;
   logic [W-1:0] div_active;
`ifdef FREC_SQUARE_OUT_EN
   logic         sq_out;
`endif

   int n_vec = 0;
   int n_err = 0;

   frec_tick_gen #(
      .WIDTH       (W),
      .DIV_DEFAULT (28'd5)
   ) dut (
      .CLK        (CLK),
      .reset      (reset),
      .en         (en),
      .oneshot    (oneshot),
      .start      (start),
      .div_load   (div_load),
      .div_val    (div_val),
      .tick       (tick),
      .busy       (busy),
      .div_err    (div_err),
      .count      (count),
      .div_active (div_active)
`ifdef FREC_SQUARE_OUT_EN
      ,
      .sq_out     (sq_out)
`endif
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // Advance one clock, then compare count, tick and div_active.
   task automatic run_chk(input string tag, input int c, input int t, input int da);
      step();
      check({tag, ".count"}, 32'(count), c);
      check({tag, ".tick"}, 32'(tick), t);
      check({tag, ".div_active"}, 32'(div_active), da);
   endtask

   task automatic shot_chk(input string tag, input int c, input int t, input int b);
      step();
      check({tag, ".count"}, 32'(count), c);
      check({tag, ".tick"}, 32'(tick), t);
      check({tag, ".busy"}, 32'(busy), b);
   endtask

   initial begin
      reset = 1'b1; en = 1'b1; oneshot = 1'b0; start = 1'b0;
      div_load = 1'b0; div_val = '0;
      step();
      step();
      check("rst.count", 32'(count), 0);
      check("rst.tick", 32'(tick), 0);
      check("rst.busy", 32'(busy), 0);
      check("rst.div_err", 32'(div_err), 0);
      check("rst.div_active", 32'(div_active), 5);

      // Continuous N=5: ticks on cycles 5, 10, 15.
      reset = 1'b0;
      for (int i = 1; i <= 15; i++) begin
         run_chk($sformatf("n5.c%0d", i), i % 5, (i % 5 == 0) ? 1 : 0, 5);
      end

      // Load 4 while stopped: applies straight away.
      en = 1'b0; div_load = 1'b1; div_val = 28'd4;
      run_chk("ld4.a", 0, 0, 5);
      div_load = 1'b0;
      run_chk("ld4.b", 0, 0, 4);

      // N=4, load 2 at count=1: switch happens on the next wrap.
      en = 1'b1;
      run_chk("ld2.c1", 1, 0, 4);
      div_load = 1'b1; div_val = 28'd2;
      run_chk("ld2.c2", 2, 0, 4);
      div_load = 1'b0;
      run_chk("ld2.c3", 3, 0, 4);
      run_chk("ld2.w1", 0, 1, 2);
      run_chk("ld2.c5", 1, 0, 2);
      run_chk("ld2.w2", 0, 1, 2);
      run_chk("ld2.c7", 1, 0, 2);

      // Load on a wrap cycle uses the old divisor for that wrap.
      div_load = 1'b1; div_val = 28'd3;
      run_chk("ldw.w", 0, 1, 2);
      div_load = 1'b0;
      run_chk("ldw.c1", 1, 0, 2);
      run_chk("ldw.w2", 0, 1, 3);
      run_chk("ldw.c3", 1, 0, 3);
      run_chk("ldw.c4", 2, 0, 3);
      run_chk("ldw.w3", 0, 1, 3);

      // Move to N=4, then freeze at count=2 for 7 cycles.
      div_load = 1'b1; div_val = 28'd4;
      run_chk("hold.a", 1, 0, 3);
      div_load = 1'b0;
      run_chk("hold.b", 2, 0, 3);
      run_chk("hold.w", 0, 1, 4);
      run_chk("hold.c", 1, 0, 4);
      run_chk("hold.d", 2, 0, 4);
      en = 1'b0;
      for (int i = 0; i < 7; i++) begin
         run_chk($sformatf("hold.frz%0d", i), 2, 0, 4);
      end
      en = 1'b1;
      run_chk("hold.r1", 3, 0, 4);
      run_chk("hold.r2", 0, 1, 4);

      // Zero divisor is rejected; period unchanged.
      div_load = 1'b1; div_val = 28'd0;
      run_chk("zero.c1", 1, 0, 4);
      check("zero.div_err", 32'(div_err), 1);
      div_load = 1'b0;
      run_chk("zero.c2", 2, 0, 4);
      run_chk("zero.c3", 3, 0, 4);
      run_chk("zero.w", 0, 1, 4);
      check("zero.sticky", 32'(div_err), 1);

      // One-shot N=3, retrigger while busy ignored.
      oneshot = 1'b1; div_load = 1'b1; div_val = 28'd3;
      run_chk("os.ld", 0, 0, 4);
      div_load = 1'b0;
      run_chk("os.apply", 0, 0, 3);
      shot_chk("os.idle", 0, 0, 0);
      start = 1'b1;
      shot_chk("os.s0", 0, 0, 1);
      start = 1'b0;
      shot_chk("os.s1", 1, 0, 1);
      start = 1'b1;
      shot_chk("os.s2", 2, 0, 1);
      start = 1'b0;
      shot_chk("os.end", 0, 1, 0);
      shot_chk("os.post1", 0, 0, 0);
      shot_chk("os.post2", 0, 0, 0);

      // oneshot drops mid-shot: shot completes, then continuous resumes.
      start = 1'b1;
      shot_chk("osd.s0", 0, 0, 1);
      start = 1'b0; oneshot = 1'b0;
      shot_chk("osd.s1", 1, 0, 1);
      shot_chk("osd.s2", 2, 0, 1);
      shot_chk("osd.end", 0, 1, 0);
      shot_chk("osd.cont1", 1, 0, 0);
      shot_chk("osd.cont2", 2, 0, 0);
      shot_chk("osd.contw", 0, 1, 0);

      // Reset mid-period restores defaults and clears div_err.
      step();
      reset = 1'b1;
      step();
      check("rst2.count", 32'(count), 0);
      check("rst2.tick", 32'(tick), 0);
      check("rst2.busy", 32'(busy), 0);
      check("rst2.div_err", 32'(div_err), 0);
      check("rst2.div_active", 32'(div_active), 5);
      reset = 1'b0;

      // N=1: tick every running cycle.
      en = 1'b0; div_load = 1'b1; div_val = 28'd1;
      run_chk("n1.ld", 0, 0, 5);
      div_load = 1'b0;
      run_chk("n1.apply", 0, 0, 1);
      en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         run_chk($sformatf("n1.t%0d", i), 0, 1, 1);
      end

`ifdef FREC_SQUARE_OUT_EN
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("sq.rst", 32'(sq_out), 0);
      en = 1'b0; div_load = 1'b1; div_val = 28'd3;
      run_chk("sq.ld", 0, 0, 5);
      div_load = 1'b0;
      run_chk("sq.apply", 0, 0, 3);
      en = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         run_chk($sformatf("sq.c%0d", i), i % 3, (i % 3 == 0) ? 1 : 0, 3);
         check($sformatf("sq.v%0d", i), 32'(sq_out), (i / 3) % 2);
      end
      reset = 1'b1;
      step();
      check("sq.rst2", 32'(sq_out), 0);
      check("sq.rst2.count", 32'(count), 0);
      check("sq.rst2.div_active", 32'(div_active), 5);
      reset = 1'b0;
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
